// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the hazard inputs and pipeline control outputs of pipeline_ctrl.
//   master : the pipeline side; drives hazard/status signals and receives the
//            stall/flush/redirect controls and the performance counters.
//   slave  : the controller side (pipeline_ctrl).
// Hazard inputs : ID_valid, ID_use_rs1/2, ID_rs1/2, EXE_valid, EXE_mem_read,
//                 EXE_rd, EXE_redirect, MEM_trap, imem_ready, dmem_req, dmem_ack
// Controls      : pc/IF_ID/ID_EXE/EXE_MEM stalls, IF_ID/ID_EXE/EXE_MEM/MEM_WB
//                 flushes, redirect_sel (00 seq, 01 EXE target, 10 trap vector)
// Counters      : stall_cnt, flush_cnt (saturating)
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             ID_valid;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic [REG_W-1:0] ID_rs1;
  logic [REG_W-1:0] ID_rs2;
  logic             EXE_valid;
  logic             EXE_mem_read;
  logic [REG_W-1:0] EXE_rd;
  logic             EXE_redirect;
  logic             MEM_trap;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ack;

  logic             pc_stall;
  logic             IF_ID_stall;
  logic             ID_EXE_stall;
  logic             EXE_MEM_stall;
  logic             IF_ID_flush;
  logic             ID_EXE_flush;
  logic             EXE_MEM_flush;
  logic             MEM_WB_flush;
  logic [1:0]       redirect_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_valid, ID_use_rs1, ID_use_rs2, ID_rs1, ID_rs2,
           EXE_valid, EXE_mem_read, EXE_rd, EXE_redirect, MEM_trap,
           imem_ready, dmem_req, dmem_ack,
    input  pc_stall, IF_ID_stall, ID_EXE_stall, EXE_MEM_stall,
           IF_ID_flush, ID_EXE_flush, EXE_MEM_flush, MEM_WB_flush,
           redirect_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_valid, ID_use_rs1, ID_use_rs2, ID_rs1, ID_rs2,
           EXE_valid, EXE_mem_read, EXE_rd, EXE_redirect, MEM_trap,
           imem_ready, dmem_req, dmem_ack,
    output pc_stall, IF_ID_stall, ID_EXE_stall, EXE_MEM_stall,
           IF_ID_flush, ID_EXE_flush, EXE_MEM_flush, MEM_WB_flush,
           redirect_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the five-stage core. Resolves traps
// from MEM, multi-cycle data-memory waits, EXE mispredict redirects, load-use
// hazards and fetch not-ready, in that priority, and counts stall cycles and
// redirect events in saturating counters.
// Ports:
//   clk  : core clock
//   rst  : synchronous active-high reset
//   bus  : pipeline_ctrl_if.slave (hazard inputs in, stall/flush/redirect and
//          counters out)
// Controls are combinational from inputs and state; state/counters are
// registered.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [REG_W-1:0] id_rs1, id_rs2, exe_rd;
  logic             load_use;

  assign id_rs1 = bus.ID_rs1;
  assign id_rs2 = bus.ID_rs2;
  assign exe_rd = bus.EXE_rd;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = bus.ID_valid && bus.EXE_valid && bus.EXE_mem_read &&
                    (exe_rd != '0) &&
                    ((bus.ID_use_rs1 && (id_rs1 == exe_rd)) ||
                     (bus.ID_use_rs2 && (id_rs2 == exe_rd)));

  // Next state and control outputs.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a signal unassigned and infer a latch.
    state_d           = state_q;
    bus.pc_stall      = 1'b0;
    bus.IF_ID_stall   = 1'b0;
    bus.ID_EXE_stall  = 1'b0;
    bus.EXE_MEM_stall = 1'b0;
    bus.IF_ID_flush   = 1'b0;
    bus.ID_EXE_flush  = 1'b0;
    bus.EXE_MEM_flush = 1'b0;
    bus.MEM_WB_flush  = 1'b0;
    bus.redirect_sel  = 2'b00;

    if (rst) begin
      state_d = RUN;
    end else if ((state_q == DWAIT) && !bus.dmem_ack) begin
      // Waiting on data memory: everything upstream of MEM holds, and a
      // bubble goes into WB. Other inputs are frozen and ignored.
      bus.pc_stall      = 1'b1;
      bus.IF_ID_stall   = 1'b1;
      bus.ID_EXE_stall  = 1'b1;
      bus.EXE_MEM_stall = 1'b1;
      bus.MEM_WB_flush  = 1'b1;
    end else begin
      // RUN, or the ack cycle of DWAIT (which skips the data-wait check so a
      // pending redirect/load-use/fetch bubble takes effect right now).
      state_d = RUN;
      if (bus.MEM_trap) begin
        bus.IF_ID_flush   = 1'b1;
        bus.ID_EXE_flush  = 1'b1;
        bus.EXE_MEM_flush = 1'b1;
        bus.redirect_sel  = 2'b10;
      end else if ((state_q == RUN) && bus.dmem_req && !bus.dmem_ack) begin
        bus.pc_stall      = 1'b1;
        bus.IF_ID_stall   = 1'b1;
        bus.ID_EXE_stall  = 1'b1;
        bus.EXE_MEM_stall = 1'b1;
        bus.MEM_WB_flush  = 1'b1;
        state_d           = DWAIT;
      end else if (bus.EXE_redirect) begin
        bus.IF_ID_flush  = 1'b1;
        bus.ID_EXE_flush = 1'b1;
        bus.redirect_sel = 2'b01;
      end else if (load_use) begin
        // Hold PC and IF_ID one cycle; the load moves on to MEM and a bubble
        // enters EXE, which clears the hazard on the next cycle.
        bus.pc_stall     = 1'b1;
        bus.IF_ID_stall  = 1'b1;
        bus.ID_EXE_flush = 1'b1;
      end else if (!bus.imem_ready) begin
        bus.pc_stall    = 1'b1;
        bus.IF_ID_flush = 1'b1;
      end
    end
  end

  // Saturating performance counters, driven from the final control outputs
  // (which are already forced to zero during reset).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if ((bus.redirect_sel != 2'b00) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
